// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - instruction prefetch queue between instruction memory and the CPU fetch input
//
// Issues sequential word reads to instruction memory over a req/ack handshake
// and buffers the returned words, tagged with their PCs, in a DEPTH-entry FIFO
// that the CPU drains with a valid/ready handshake. A redirect flushes the
// FIFO, discards any in-flight word and restarts fetching at redirect_pc.
//
// Optional feature macro: PREFETCH_QUEUE_STATS_EN adds the drop_cnt port, a
// 16-bit saturating count of discarded memory words.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   redirect/redirect_pc flush and restart fetching at redirect_pc
//   mem_req/mem_addr     read request and byte address to instruction memory
//   mem_ack/mem_rdata    one-cycle acknowledge with the returned word
//   instr_valid          FIFO head holds a valid word
//   instruction/pc       head word and its address
//   instr_ready          CPU accepts the head this cycle
//   count                current FIFO occupancy
//   drop_cnt             discarded-word counter (PREFETCH_QUEUE_STATS_EN only)
module prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         PW       = $clog2(DEPTH),
  localparam int         CW       = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          mem_req,
  output logic [31:0]   mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic          instr_valid,
  output logic [31:0]   instruction,
  output logic [31:0]   pc,
  input  logic          instr_ready,
  output logic [CW-1:0] count
`ifdef PREFETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   word_d [DEPTH];
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   addr_d [DEPTH];

  logic          pop;
  logic          push;
  logic [CW-1:0] count_after;
  logic [31:0]   next_pc;

  always_comb begin
    pop         = (count_q != '0) && instr_ready;
    next_pc     = fetch_pc_q + 32'd4;
    // Occupancy after this cycle's push and pop; in WAIT count_q < DEPTH,
    // so the +1 cannot overflow CW bits.
    count_after = count_q + CW'(1) - (pop ? CW'(1) : CW'(0));

    state_d    = state_q;
    fetch_pc_d = redirect ? redirect_pc : fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          // Flush makes room, so the new address is requested right away.
          state_d    = S_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = redirect_pc;
        end else if (count_q < DEPTH_C) begin
          state_d    = S_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          if (redirect) begin
            // The acked word belongs to the old stream: drop it and request
            // the redirect target without leaving WAIT.
            mem_addr_d = redirect_pc;
          end else begin
            push       = 1'b1;
            fetch_pc_d = next_pc;
            if (count_after < DEPTH_C) begin
              mem_addr_d = next_pc;
            end else begin
              state_d   = S_IDLE;
              mem_req_d = 1'b0;
            end
          end
        end else if (redirect) begin
          // Request must stay stable until acked; its data is discarded later.
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    word_d   = word_q;
    addr_d   = addr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      // A same-cycle pop has already been taken by the CPU; the flush
      // simply discards everything that is left.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        word_d[wr_ptr_q] = mem_rdata;
        addr_d[wr_ptr_q] = mem_addr_q;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + (push ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
    end
  end

`ifdef PREFETCH_QUEUE_STATS_EN
  logic        discard;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // A word is discarded when it is acked in DROP or acked alongside a redirect.
  assign discard = mem_ack && (((state_q == S_WAIT) && redirect) || (state_q == S_DROP));

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (discard && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  // Head outputs come straight from registers; a new word is visible only
  // the cycle after its ack.
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign count       = count_q;
  assign instr_valid = (count_q != '0);
  assign instruction = word_q[rd_ptr_q];
  assign pc          = addr_q[rd_ptr_q];

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - self-checking bench for prefetch_queue
module tb_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          instr_valid;
  logic [31:0]   instruction;
  logic [31:0]   pc;
  logic          instr_ready = 1'b0;
  logic [CW-1:0] count;
`ifdef PREFETCH_QUEUE_STATS_EN
  logic [15:0]   drop_cnt;
`endif

  prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .pc          (pc),
    .instr_ready (instr_ready),
    .count       (count)
`ifdef PREFETCH_QUEUE_STATS_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          lat = 0;
  int          wait_cnt = 0;
  bit          mem_busy = 0;
  logic [31:0] req_addr = '0;
  int          req_epoch = 0;
  int          epoch = 0;
  int          n_acks = 0;
  logic [31:0] last_ack_addr = '0;
  logic [63:0] sb_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory model answers, scoreboard updates, then the edge.
  task automatic cycle();
    logic [63:0] e;
    logic        ack;
    ack = 1'b0;
    if (mem_req) begin
      if (!mem_busy) begin
        mem_busy  = 1'b1;
        req_addr  = mem_addr;
        req_epoch = epoch;
        wait_cnt  = 0;
      end else begin
        chk("addr_stable", mem_addr, req_addr);
      end
      if (wait_cnt >= lat) ack = 1'b1;
      else wait_cnt++;
    end else begin
      mem_busy = 1'b0;
    end
    mem_ack   = ack;
    mem_rdata = ack ? mem_word(req_addr) : 32'h0;

    if (instr_valid && instr_ready) begin
      if (sb_q.size() == 0) begin
        chk("pop_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pc", pc, e[63:32]);
        chk("sb_instruction", instruction, e[31:0]);
      end
    end
    if (redirect) begin
      sb_q.delete();
      epoch++;
    end
    if (ack) begin
      n_acks++;
      last_ack_addr = req_addr;
      mem_busy = 1'b0;
      if (req_epoch == epoch && !redirect) sb_q.push_back({req_addr, mem_word(req_addr)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    sb_q.delete();
    mem_busy = 0;
    wait_cnt = 0;
    epoch = 0;
    n_acks = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_count", count, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_pc", pc, 0);
`ifdef PREFETCH_QUEUE_STATS_EN
    chk("rst_drop_cnt", drop_cnt, 0);
`endif
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int a0;

    // Zero-wait stream: one word per cycle, pc 0,4,8,...
    lat = 0;
    instr_ready = 1'b1;
    do_reset();
    cycle();
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, 32'h0);
    chk("first_count", count, 0);
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("stream_valid", instr_valid, 1);
      chk("stream_pc", pc, 32'(i * 4));
    end

    // CPU stalled: exactly DEPTH acks, then one pop frees one slot.
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) cycle();
    chk("full_acks", n_acks, 4);
    chk("full_mem_req", mem_req, 0);
    chk("full_count", count, 4);
    chk("full_pc", pc, 32'h0);
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    n_acks = 0;
    for (int i = 0; i < 6; i++) cycle();
    chk("refill_acks", n_acks, 1);
    chk("refill_addr", last_ack_addr, 32'h10);
    chk("refill_count", count, 4);
    chk("refill_mem_req", mem_req, 0);
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();

    // Slow memory: redirect while the request to 0x8 is outstanding.
    lat = 2;
    instr_ready = 1'b1;
    do_reset();
    n = 0;
    while (!(mem_req && mem_addr == 32'h8) && n < 40) begin cycle(); n++; end
    chk("wait_req8", n < 40, 1);
    cycle();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0;
    chk("drop_req_held", mem_req, 1);
    chk("drop_addr_held", mem_addr, 32'h8);
    a0 = n_acks;
    n = 0;
    while (n_acks == a0 && n < 10) begin cycle(); n++; end
    chk("drop_ack_seen", n < 10, 1);
    chk("drop_ack_addr", last_ack_addr, 32'h8);
    n = 0;
    while (!mem_req && n < 10) begin cycle(); n++; end
    chk("redir_req_addr", mem_addr, 32'h100);
`ifdef PREFETCH_QUEUE_STATS_EN
    chk("drop_cnt_slow", drop_cnt, 1);
`endif
    n = 0;
    while (!instr_valid && n < 20) begin cycle(); n++; end
    chk("redir_pc_100", pc, 32'h100);
    for (int i = 0; i < 6; i++) cycle();

    // Redirect coinciding with a pop and an ack.
    lat = 0;
    instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) cycle();
    chk("pre_redir_valid", instr_valid, 1);
    chk("pre_redir_req", mem_req, 1);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    cycle();
    redirect = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", instr_valid, 0);
    n = 0;
    while (!instr_valid && n < 10) begin cycle(); n++; end
    chk("redir_pc_40", pc, 32'h40);
`ifdef PREFETCH_QUEUE_STATS_EN
    chk("drop_cnt_same", drop_cnt, 1);
`endif
    for (int i = 0; i < 4; i++) cycle();

    // Asynchronous reset mid-operation.
    lat = 2;
    instr_ready = 1'b0;
    do_reset();
    n = 0;
    while (!(count == 2 && mem_req) && n < 40) begin cycle(); n++; end
    chk("wait_count2", n < 40, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_count", count, 0);
    chk("arst_valid", instr_valid, 0);
    do_reset();
    cycle();
    chk("restart_req", mem_req, 1);
    chk("restart_addr", mem_addr, 32'h0);

    // Address wrap past the top of memory.
    lat = 0;
    instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) cycle();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    n = 0;
    while (!instr_valid && n < 10) begin cycle(); n++; end
    chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_valid", instr_valid, 1);
    chk("wrap_pc_zero", pc, 32'h0);
    for (int i = 0; i < 4; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Instruction prefetch stage between instruction memory and the `cpu` fetch input. It issues sequential word reads to memory through a request/acknowledge handshake and buffers returned words with their PCs in a DEPTH-entry FIFO. The CPU pops them with a valid/ready handshake. A redirect from the CPU (branch/jump) flushes the queue, discards any in-flight word and restarts fetching at the new PC.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `redirect` in 1: flush the queue and restart fetching at `redirect_pc`.
- `redirect_pc` in 32: new fetch address, sampled when `redirect`=1.
- `mem_req` out 1: read request to instruction memory.
- `mem_addr` out 32: byte address of the request.
- `mem_ack` in 1: one-cycle acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: returned instruction word.
- `instr_valid` out 1: queue head holds a valid word.
- `instruction` out 32: head word.
- `pc` out 32: address of the head word.
- `instr_ready` in 1: CPU accepts the head this cycle.
- `count` out clog2(DEPTH)+1: current occupancy.
- `drop_cnt` out 16: discarded-word counter. Present only with `PREFETCH_QUEUE_STATS_EN`.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DROP: request outstanding, result to be discarded.
- Reset values: state=IDLE, fetch_pc=`RESET_PC`, `mem_req`=0, `mem_addr`=`RESET_PC`, FIFO empty, `count`=0, `instr_valid`=0, `instruction`=0, `pc`=0, `drop_cnt`=0.
- Request rule: while `mem_req`=1, `mem_addr` stays stable until `mem_ack`. The only exception is `rst`, which drops `mem_req` immediately; memory must tolerate an abandoned request.
- Issue condition: count + (WAIT ? 1 : 0) < DEPTH, so the FIFO can never overflow.
- IDLE → WAIT when the issue condition holds and `redirect`=0. Drives `mem_req`=1, `mem_addr`=fetch_pc.
- WAIT with `mem_ack`:
  - The word and `mem_addr` are pushed; fetch_pc += 4 (wraps modulo 2^32).
  - If space remains after the push/pop, the next request is issued immediately (stay in WAIT, `mem_addr` = new fetch_pc). Otherwise go to IDLE.
- WAIT with `redirect` and no `mem_ack`: go to DROP. `mem_req` stays high on the old address.
- DROP with `mem_ack`: the word is discarded, `drop_cnt`++. Go to IDLE, then issue fetch_pc.
- Redirect (any state):
  - FIFO is cleared at the next edge; fetch_pc = `redirect_pc`.
  - A `mem_ack` in the same cycle is discarded and counted.
  - A pop in the same cycle completes (the CPU has consumed the word), then the flush applies.
  - A second redirect while in DROP overwrites fetch_pc; only the last one wins.
- Pop: `instr_valid` && `instr_ready` advances the head.
- Simultaneous push and pop leave `count` unchanged.
- Pop while empty is ignored.
- `instr_valid` = (count ≠ 0), driven from registers only, with no combinational path from `mem_ack`.
- Pointers are clog2(DEPTH) bits and wrap naturally.

## Timing
- First request: `mem_req`=1 in the first cycle after `rst` deasserts.
- Memory to CPU latency: a `mem_ack` at edge N makes `instr_valid`=1 from edge N onward (visible cycle N+1). There is no same-cycle bypass.
- Throughput: 1 word/cycle with a zero-wait memory (`mem_ack` tied high).
- Redirect penalty: redirect at edge N produces the new request in cycle N+1 from IDLE/WAIT. From DROP, the new request appears one cycle after the discarded ack.
- `rst` asserted mid-operation clears all state asynchronously, with no wait for edges.

## Configuration
- `PREFETCH_QUEUE_STATS_EN` defined: the `drop_cnt` port exists. It is a 16-bit saturating counter (holds at 16'hFFFF) of discarded memory words, cleared only by `rst`.
- Undefined: the port and its counter are absent; functional behaviour is otherwise identical.

## Test plan
- Reset, `mem_ack` tied 1, `instr_ready`=1: `pc` sequence is 0,4,8,C… on consecutive cycles; `instruction` equals the memory model contents.
- `instr_ready`=0, DEPTH=4: exactly 4 acks occur, then `mem_req`=0 and `count`=4. A single pop produces exactly one new request to address 0x10.
- 3-cycle memory latency: redirect to 0x100 one cycle after a request to 0x8 is issued. `mem_addr` holds 0x8 until ack; that word never appears; the next request is to 0x100; `drop_cnt`=1.
- Redirect to 0x40 in the same cycle as a pop and an ack: the popped word is consumed, the acked word is dropped, the FIFO is empty next cycle, and the next `pc` is 0x40.
- Assert `rst` while `mem_req`=1 and `count`=2: in the same cycle `mem_req`=0, `count`=0, `instr_valid`=0. After release, the fetch restarts at `RESET_PC`.
- Redirect to 0xFFFF_FFFC with a fast memory: `pc` shows 0xFFFF_FFFC then 0x0000_0000 (wrap).
